// File: rtl/kv_uart_pkg.sv
// Shared types and helpers for the UART key-value command receive path.
// Holds the frame parser state encoding, parameter defaults and the checksum step.
package kv_uart_pkg;

    localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;
    localparam int         MAX_VAL_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE,
        OP,
        KEY,
        LEN,
        VAL,
        CHK,
        HOLD
    } kv_state_t;

    // Running frame checksum: XOR of every byte from OP through the last value byte.
    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/toggle_sync_edge.sv
// Brings a toggle-per-event signal into the clk domain and emits a one-cycle event
// strobe on every level change. Shared by the receive and transmit-done paths.
module toggle_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic tog,
    output logic evt
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= tog;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign evt = sync_p1 ^ prev_p2;

endmodule

// File: rtl/uart_kv_frame_ctrl.sv
// Parses SOF/OP/KEY/LEN/VAL/CHK frames from the UART byte receiver and hands each
// validated command to the key-value decoder over a valid/ready handshake.
module uart_kv_frame_ctrl
    import kv_uart_pkg::*;
#(
    parameter int         MAX_VAL       = MAX_VAL_DEF,
    parameter int         LEN_W         = 3,
    parameter logic [7:0] SOF_BYTE      = SOF_BYTE_DEF,
    parameter int         TIMEOUT_TICKS = 160
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_toggle,
    input  logic                 baud_tick,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [7:0]           cmd_op,
    output logic [7:0]           cmd_key,
    output logic [LEN_W-1:0]     cmd_len,
    output logic [8*MAX_VAL-1:0] cmd_value,
    output logic                 err_chk,
    output logic                 err_len,
    output logic                 err_timeout,
    output logic                 err_overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

    kv_state_t        state;
    kv_state_t        state_nxt;
    logic             byte_evt;
    logic [7:0]       chk_acc;
    logic [LEN_W-1:0] idx;
    logic [CNT_W-1:0] to_cnt;
    logic             in_frame;
    logic             expire;
    logic             len_ok;
    logic             err_chk_nxt;
    logic             err_len_nxt;
    logic             err_timeout_nxt;
    logic             err_overrun_nxt;

    toggle_sync_edge u_rx_sync (
        .clk (clk),
        .rst (rst),
        .tog (rx_toggle),
        .evt (byte_evt)
    );

    assign in_frame = (state == OP) || (state == KEY) || (state == LEN) ||
                      (state == VAL) || (state == CHK);
    // A byte landing on the expiring tick wins: the frame is still alive.
    assign expire   = in_frame && baud_tick && !byte_evt &&
                      (to_cnt == CNT_W'(TIMEOUT_TICKS - 1));
    assign len_ok   = (rx_byte != 8'h00) && (rx_byte <= 8'(MAX_VAL));

    assign cmd_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt       = state;
        err_chk_nxt     = 1'b0;
        err_len_nxt     = 1'b0;
        err_timeout_nxt = 1'b0;
        err_overrun_nxt = 1'b0;
        case (state)
            IDLE: if (byte_evt && rx_byte == SOF_BYTE) state_nxt = OP;
            OP:   if (byte_evt) state_nxt = KEY;
            KEY:  if (byte_evt) state_nxt = LEN;
            LEN: begin
                if (byte_evt) begin
                    if (len_ok) begin
                        state_nxt = VAL;
                    end else begin
                        state_nxt   = IDLE;
                        err_len_nxt = 1'b1;
                    end
                end
            end
            VAL:  if (byte_evt && idx == cmd_len - LEN_W'(1)) state_nxt = CHK;
            CHK: begin
                if (byte_evt) begin
                    if (rx_byte == chk_acc) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt   = IDLE;
                        err_chk_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Bytes arriving while a command is held, even on the accept cycle, are lost.
                err_overrun_nxt = byte_evt;
                if (cmd_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (expire) begin
            state_nxt       = IDLE;
            err_timeout_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            err_chk     <= err_chk_nxt;
            err_len     <= err_len_nxt;
            err_timeout <= err_timeout_nxt;
            err_overrun <= err_overrun_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (!in_frame || byte_evt || expire) begin
            to_cnt <= '0;
        end else if (baud_tick) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // Field capture: only parsing states touch the command registers, so HOLD keeps them stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_op    <= '0;
            cmd_key   <= '0;
            cmd_len   <= '0;
            cmd_value <= '0;
            chk_acc   <= '0;
            idx       <= '0;
        end else if (byte_evt) begin
            case (state)
                OP: begin
                    cmd_op  <= rx_byte;
                    chk_acc <= rx_byte;
                end
                KEY: begin
                    cmd_key <= rx_byte;
                    chk_acc <= chk_update(chk_acc, rx_byte);
                end
                LEN: begin
                    if (len_ok) begin
                        cmd_len   <= rx_byte[LEN_W-1:0];
                        cmd_value <= '0;
                        idx       <= '0;
                        chk_acc   <= chk_update(chk_acc, rx_byte);
                    end
                end
                VAL: begin
                    for (int i = 0; i < MAX_VAL; i++) begin
                        if (idx == LEN_W'(i)) cmd_value[8*i +: 8] <= rx_byte;
                    end
                    chk_acc <= chk_update(chk_acc, rx_byte);
                    idx     <= idx + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_kv_frame_ctrl.sv
// Scenario bench for uart_kv_frame_ctrl: expected commands and error pulses are queued
// as frames are driven and matched as the DUT produces them.
module tb_uart_kv_frame_ctrl;

    localparam int MAX_VAL = 4;
    localparam int LEN_W   = 3;
    localparam int EV_CHK  = 1;
    localparam int EV_LEN  = 2;
    localparam int EV_TO   = 3;
    localparam int EV_OVR  = 4;

    typedef struct {
        logic [7:0]           op;
        logic [7:0]           key;
        logic [LEN_W-1:0]     len;
        logic [8*MAX_VAL-1:0] val;
    } cmd_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [7:0]           rx_byte = 8'h00;
    logic                 rx_toggle = 1'b0;
    logic                 baud_tick = 1'b0;
    logic                 cmd_ready = 1'b1;
    logic                 cmd_valid;
    logic [7:0]           cmd_op;
    logic [7:0]           cmd_key;
    logic [LEN_W-1:0]     cmd_len;
    logic [8*MAX_VAL-1:0] cmd_value;
    logic                 err_chk;
    logic                 err_len;
    logic                 err_timeout;
    logic                 err_overrun;
    logic                 busy;

    cmd_t exp_cmd_q[$];
    int   exp_err_q[$];
    int   total = 0;
    int   bad   = 0;

    uart_kv_frame_ctrl #(.MAX_VAL(MAX_VAL), .LEN_W(LEN_W), .SOF_BYTE(8'hA5), .TIMEOUT_TICKS(160)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_toggle(rx_toggle), .baud_tick(baud_tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key),
        .cmd_len(cmd_len), .cmd_value(cmd_value), .err_chk(err_chk), .err_len(err_len),
        .err_timeout(err_timeout), .err_overrun(err_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; a handshake is judged on the values present going into the edge,
    // error pulses on the values registered by it.
    task automatic cycle();
        cmd_t snap;
        cmd_t e;
        logic hs;
        int   n;
        int   k;
        int   w;
        hs = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
        snap.op = cmd_op; snap.key = cmd_key; snap.len = cmd_len; snap.val = cmd_value;
        @(negedge clk);
        if (hs) begin
            total++;
            if (exp_cmd_q.size() == 0) begin
                bad++;
                $display("FAIL sb_cmd: unexpected command op=%h key=%h len=%0d val=%h", snap.op, snap.key, snap.len, snap.val);
            end else begin
                e = exp_cmd_q.pop_front();
                if (snap.op !== e.op || snap.key !== e.key || snap.len !== e.len || snap.val !== e.val) begin
                    bad++;
                    $display("FAIL sb_cmd: got op=%h key=%h len=%0d val=%h want op=%h key=%h len=%0d val=%h",
                             snap.op, snap.key, snap.len, snap.val, e.op, e.key, e.len, e.val);
                end
            end
        end
        n = int'(err_chk) + int'(err_len) + int'(err_timeout) + int'(err_overrun);
        if (n != 0) begin
            total++;
            k = err_chk ? EV_CHK : err_len ? EV_LEN : err_timeout ? EV_TO : EV_OVR;
            if (n > 1) begin
                bad++;
                $display("FAIL sb_err: %0d error pulses in one cycle, want at most 1", n);
            end else if (exp_err_q.size() == 0) begin
                bad++;
                $display("FAIL sb_err: unexpected error kind=%0d, none expected", k);
            end else begin
                w = exp_err_q.pop_front();
                if (k != w) begin
                    bad++;
                    $display("FAIL sb_err: got error kind=%0d want kind=%0d", k, w);
                end
            end
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        rx_byte   = b;
        rx_toggle = ~rx_toggle;
    endtask

    task automatic send_byte(input logic [7:0] b);
        put_byte(b);
        repeat (4) cycle();
    endtask

    task automatic push_cmd(input logic [7:0] op, input logic [7:0] key, input int len,
                            input logic [8*MAX_VAL-1:0] val);
        cmd_t c;
        c.op = op; c.key = key; c.len = LEN_W'(len); c.val = val;
        exp_cmd_q.push_back(c);
    endtask

    // Sends a complete well-formed frame with its checksum computed here.
    task automatic send_frame(input logic [7:0] op, input logic [7:0] key, input int len,
                              input logic [8*MAX_VAL-1:0] val);
        logic [7:0] chk;
        logic [8*MAX_VAL-1:0] v;
        v   = val;
        chk = op ^ key ^ 8'(len);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(key);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            chk = chk ^ v[8*i +: 8];
            send_byte(v[8*i +: 8]);
        end
        send_byte(chk);
    endtask

    task automatic check_reset_vals(input string tag);
        total++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || err_chk !== 1'b0 || err_len !== 1'b0 ||
            err_timeout !== 1'b0 || err_overrun !== 1'b0 || cmd_op !== 8'h00 ||
            cmd_key !== 8'h00 || cmd_len !== '0 || cmd_value !== '0) begin
            bad++;
            $display("FAIL %s: got valid=%b busy=%b errs=%b%b%b%b op=%h key=%h len=%0d val=%h want all zero",
                     tag, cmd_valid, busy, err_chk, err_len, err_timeout, err_overrun,
                     cmd_op, cmd_key, cmd_len, cmd_value);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cycle();
        check_reset_vals("reset_state");
        rst = 1'b0;
        repeat (4) cycle();
        check_reset_vals("idle_after_reset");
    endtask

    task automatic test_good_frame();
        cmd_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
        push_cmd(8'h01, 8'h10, 2, 32'h0000CDAB);
        put_byte(8'h75);
        cycle(); cycle();
        total++;
        if (cmd_valid !== 1'b0) begin
            bad++; $display("FAIL valid_early: got cmd_valid=%b want 0", cmd_valid);
        end
        cycle();
        total++;
        if (cmd_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL valid_latency: got cmd_valid=%b busy=%b want 1 1", cmd_valid, busy);
        end
        cycle();
        total++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL after_accept: got cmd_valid=%b busy=%b want 0 0", cmd_valid, busy);
        end
        repeat (2) cycle();
    endtask

    task automatic test_bad_chk();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
        exp_err_q.push_back(EV_CHK);
        put_byte(8'h74);
        repeat (3) cycle();
        total++;
        if (err_chk !== 1'b1 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bad_chk: got err_chk=%b cmd_valid=%b busy=%b want 1 0 0", err_chk, cmd_valid, busy);
        end
        repeat (2) cycle();
        push_cmd(8'h02, 8'h20, 1, 32'h0000005A);
        send_frame(8'h02, 8'h20, 1, 32'h0000005A);
    endtask

    task automatic test_len_err();
        exp_err_q.push_back(EV_LEN);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h05);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL len_over_idle: got busy=%b want 0", busy);
        end
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h75);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL len_ignore_tail: got busy=%b want 0", busy);
        end
        exp_err_q.push_back(EV_LEN);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL len_zero_idle: got busy=%b want 0", busy);
        end
        push_cmd(8'h03, 8'h30, 4, 32'h44332211);
        send_frame(8'h03, 8'h30, 4, 32'h44332211);
    endtask

    task automatic test_timeout();
        send_byte(8'hA5); send_byte(8'h01);
        exp_err_q.push_back(EV_TO);
        for (int i = 0; i < 159; i++) begin
            baud_tick = 1'b1; cycle(); baud_tick = 1'b0; cycle();
        end
        total++;
        if (busy !== 1'b1 || err_timeout !== 1'b0) begin
            bad++; $display("FAIL timeout_early: got busy=%b err_timeout=%b want 1 0", busy, err_timeout);
        end
        baud_tick = 1'b1; cycle(); baud_tick = 1'b0;
        total++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_fire: got err_timeout=%b busy=%b want 1 0", err_timeout, busy);
        end
        repeat (2) cycle();
        // Same run-up, but the KEY byte lands on the 160th tick.
        send_byte(8'hA5); send_byte(8'h01);
        for (int i = 0; i < 159; i++) begin
            baud_tick = 1'b1; cycle(); baud_tick = 1'b0; cycle();
        end
        put_byte(8'h10);
        cycle(); cycle();
        baud_tick = 1'b1; cycle(); baud_tick = 1'b0;
        total++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL timeout_byte_wins: got err_timeout=%b busy=%b want 0 1", err_timeout, busy);
        end
        cycle();
        push_cmd(8'h01, 8'h10, 1, 32'h00000077);
        send_byte(8'h01); send_byte(8'h77); send_byte(8'h67);
    endtask

    task automatic test_overrun();
        cmd_ready = 1'b0;
        push_cmd(8'h04, 8'h40, 1, 32'h00000099);
        send_frame(8'h04, 8'h40, 1, 32'h00000099);
        exp_err_q.push_back(EV_OVR);
        put_byte(8'h3C);
        for (int i = 0; i < 50; i++) begin
            cycle();
            total++;
            if (cmd_valid !== 1'b1 || cmd_op !== 8'h04 || cmd_key !== 8'h40 ||
                cmd_len !== 3'd1 || cmd_value !== 32'h00000099) begin
                bad++;
                $display("FAIL hold_stable: got valid=%b op=%h key=%h len=%0d val=%h want 1 04 40 1 00000099",
                         cmd_valid, cmd_op, cmd_key, cmd_len, cmd_value);
            end
        end
        cmd_ready = 1'b1;
        cycle();
        cycle();
        total++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            bad++; $display("FAIL hold_release: got busy=%b cmd_valid=%b want 0 0", busy, cmd_valid);
        end
    endtask

    task automatic test_back_to_back();
        // An SOF landing on the accept cycle is an overrun, so the tail must not parse.
        cmd_ready = 1'b0;
        push_cmd(8'h05, 8'h50, 1, 32'h00000066);
        send_frame(8'h05, 8'h50, 1, 32'h00000066);
        exp_err_q.push_back(EV_OVR);
        put_byte(8'hA5);
        cycle(); cycle();
        cmd_ready = 1'b1;
        cycle();
        total++;
        if (err_overrun !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL accept_overrun: got err_overrun=%b busy=%b want 1 0", err_overrun, busy);
        end
        cycle();
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h01); send_byte(8'h77); send_byte(8'h67);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL accept_sof_dropped: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h70);
        rst = 1'b1;
        cycle(); cycle();
        check_reset_vals("reset_mid_frame");
        rst = 1'b0;
        repeat (4) cycle();
        check_reset_vals("reset_mid_release");
        send_byte(8'h00); send_byte(8'hFF);
        push_cmd(8'h06, 8'h60, 3, 32'h00030201);
        send_frame(8'h06, 8'h60, 3, 32'h00030201);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_len_err();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        repeat (4) cycle();
        total++;
        if (exp_cmd_q.size() != 0 || exp_err_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d commands and %0d errors still expected want 0 0",
                     exp_cmd_q.size(), exp_err_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
